// File: rtl/uart_tx_result_ctrl.sv
// Transmit side of the UART calculator link: captures an N-bit result on trigger and
// sends it as uppercase ASCII hex digits (MSB first), optionally followed by CR LF.
module uart_tx_result_ctrl #(
    parameter int unsigned N           = 16,
    parameter int unsigned SEND_CRLF   = 1,
    parameter int unsigned ACK_TIMEOUT = 1024
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         trigger,
    input  logic [N-1:0] value,
    input  logic         tx_busy,
    output logic         tx_start,
    output logic [7:0]   tx_data,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int unsigned DIGITS = N / 4;
    localparam int unsigned LEN    = DIGITS + 2 * SEND_CRLF;
    localparam int unsigned IDX_W  = $clog2(LEN + 1);
    localparam int unsigned CNT_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t             state;
    logic [N-1:0]       data_q;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic [7:0]         char_c;
    logic               last_c;

    function automatic logic [7:0] hex_ascii(input logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
    endfunction

    // The captured value shifts left one nibble per digit, so the top nibble is always next.
    always_comb begin
        char_c = 8'h0A;
        if (idx < IDX_W'(DIGITS)) begin
            char_c = hex_ascii(data_q[N-1 -: 4]);
        end else if (idx == IDX_W'(DIGITS)) begin
            char_c = 8'h0D;
        end
    end

    assign last_c = (idx == IDX_W'(LEN - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            idx      <= '0;
            cnt      <= '0;
            data_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        data_q <= value;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= SEND;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= char_c;
                        data_q   <= data_q << 4;
                        cnt      <= '0;
                        state    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    tx_start <= 1'b0;
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                        // Transmitter never acknowledged: flag it and move on as if sent.
                        err <= 1'b1;
                        if (last_c) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= SEND;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (last_c) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
